// File: rtl/led_flow_pkg.sv
// Shared mode encodings, sweep direction type and the LED pattern helper
// used by the LED flow engine.
package led_flow_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SHIFT_UP   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SHIFT_DOWN = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE     = 2'd2;
  localparam logic [MODE_W-1:0] MODE_FILL       = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // One bit of the true-polarity pattern: bar graph in FILL, one-hot otherwise.
  function automatic logic pattern_bit(input logic [MODE_W-1:0] mode,
                                       input int unsigned pos,
                                       input int unsigned idx);
    if (mode == MODE_FILL)
      return (idx < pos);
    else
      return (idx == pos);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every div_q+1 running cycles.
// A mode change (clear) or a divider load restarts the count and eats the tick.
module led_tick_prescaler #(
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 4999999
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;

  assign tick = run & (cnt == div_q) & ~div_load & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= RESET_DIV;
    end else begin
      if (div_load)
        div_q <= div_value;
      if (clear || div_load || tick)
        cnt <= '0;
      else if (run)
        cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_flow_engine.sv
// LED pattern engine: advances a shift/bounce/fill pattern on each prescaler
// tick and drives registered LEDs with selectable polarity.
module led_flow_engine
  import led_flow_pkg::*;
#(
  parameter int          N_LEDS      = 8,
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 4999999,
  parameter int          ACTIVE_LOW  = 1,
  localparam int         PW          = $clog2(N_LEDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic [N_LEDS-1:0]    leds,
  output logic [PW-1:0]        position,
  output logic                 step
);

  localparam logic [PW-1:0]     LAST_POS   = PW'(N_LEDS - 1);
  localparam logic [PW-1:0]     FULL_POS   = PW'(N_LEDS);
  localparam logic [PW-1:0]     ONE_POS    = PW'(1);
  localparam logic [N_LEDS-1:0] RESET_PAT  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] RESET_LEDS = (ACTIVE_LOW != 0) ? ~RESET_PAT : RESET_PAT;

  logic [MODE_W-1:0] mode_q;
  dir_t              dir, next_dir;
  logic [PW-1:0]     next_pos;
  logic [MODE_W-1:0] pat_mode;
  logic [N_LEDS-1:0] next_pat, next_leds;
  logic              mode_change, tick;

  assign mode_change = (mode != mode_q);

  led_tick_prescaler #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .clear     (mode_change),
    .div_load  (div_load),
    .div_value (div_value),
    .tick      (tick)
  );

  // Next position/direction; a mode change restarts the new mode at position 0.
  always_comb begin
    next_pos = position;
    next_dir = dir;
    pat_mode = mode_q;
    if (mode_change) begin
      next_pos = '0;
      next_dir = DIR_UP;
      pat_mode = mode;
    end else if (tick) begin
      case (mode_q)
        MODE_SHIFT_UP:   next_pos = (position == LAST_POS) ? '0 : position + ONE_POS;
        MODE_SHIFT_DOWN: next_pos = (position == '0) ? LAST_POS : position - ONE_POS;
        MODE_BOUNCE: begin
          if (N_LEDS == 1) begin
            next_pos = '0;
          end else begin
            next_pos = (dir == DIR_UP) ? position + ONE_POS : position - ONE_POS;
            if (next_pos == LAST_POS)
              next_dir = DIR_DOWN;
            else if (next_pos == '0)
              next_dir = DIR_UP;
          end
        end
        MODE_FILL:       next_pos = (position == FULL_POS) ? '0 : position + ONE_POS;
        default:         next_pos = position;
      endcase
    end
  end

  always_comb begin
    next_pat = '0;
    for (int unsigned i = 0; i < N_LEDS; i++)
      next_pat[i] = pattern_bit(pat_mode, 32'(next_pos), i);
    next_leds = (ACTIVE_LOW != 0) ? ~next_pat : next_pat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_SHIFT_UP;
      position <= '0;
      dir      <= DIR_UP;
      leds     <= RESET_LEDS;
      step     <= 1'b0;
    end else begin
      mode_q <= mode;
      step   <= tick;
      if (mode_change || tick) begin
        position <= next_pos;
        dir      <= next_dir;
        leds     <= next_leds;
      end
    end
  end

endmodule

// File: tb/tb_led_flow_engine.sv
// Directed bench for led_flow_engine: an N=8 active-low instance and an
// N=4 active-high instance sharing clock and reset.
module tb_led_flow_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run8, run4;
  logic [1:0]  mode8, mode4;
  logic        div_load8, div_load4;
  logic [31:0] div_value8, div_value4;
  logic [7:0]  leds8;
  logic [3:0]  pos8;
  logic        step8;
  logic [3:0]  leds4;
  logic [2:0]  pos4;
  logic        step4;
  logic        step_seen;

  int checks = 0;
  int passed = 0;

  int bounce_pos [7] = '{1, 2, 3, 2, 1, 0, 1};
  int fill_pos   [5] = '{1, 2, 3, 4, 0};
  int fill_leds  [5] = '{1, 3, 7, 15, 0};

  always #5 clk = ~clk;

  led_flow_engine #(
    .N_LEDS(8), .DIV_WIDTH(32), .DEFAULT_DIV(3), .ACTIVE_LOW(1)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .run(run8), .mode(mode8),
    .div_load(div_load8), .div_value(div_value8),
    .leds(leds8), .position(pos8), .step(step8)
  );

  led_flow_engine #(
    .N_LEDS(4), .DIV_WIDTH(32), .DEFAULT_DIV(7), .ACTIVE_LOW(0)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run4), .mode(mode4),
    .div_load(div_load4), .div_value(div_value4),
    .leds(leds4), .position(pos4), .step(step4)
  );

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      passed++;
  endtask

  function automatic logic [7:0] onehot_low8(input int pos);
    logic [7:0] v;
    v = 8'd1 << pos;
    return ~v;
  endfunction

  // Checks position, LED drive and step of the 8-LED instance in one go.
  task automatic check8(input string tag, input int pos, input logic stp);
    check_output({tag, " pos"},  32'(pos8),  32'(pos));
    check_output({tag, " leds"}, 32'(leds8), 32'(onehot_low8(pos)));
    check_output({tag, " step"}, 32'(step8), 32'(stp));
  endtask

  initial begin
    reset_n    = 1'b0;
    run8       = 1'b0;  run4       = 1'b0;
    mode8      = 2'd0;  mode4      = 2'd0;
    div_load8  = 1'b0;  div_load4  = 1'b0;
    div_value8 = '0;    div_value4 = '0;
    cycles(2);
    check8("reset8", 0, 1'b0);
    check_output("reset4 leds", 32'(leds4), 32'h1);
    check_output("reset4 pos",  32'(pos4),  32'd0);

    // First tick arrives DEFAULT_DIV+1 = 4 run cycles after reset release.
    reset_n = 1'b1;
    run8    = 1'b1;
    cycles(3);
    check8("default div wait", 0, 1'b0);
    cycles(1);
    check8("default div tick", 1, 1'b1);

    div_load8  = 1'b1;
    div_value8 = 32'd2;
    cycles(1);
    div_load8  = 1'b0;
    check8("div load", 1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycles(2);
      check_output("shift up idle step", 32'(step8), 32'd0);
      cycles(1);
      check8("shift up", (1 + k) % 8, 1'b1);
    end

    // Divider 5, pause after two ticks plus two counts.
    div_load8  = 1'b1;
    div_value8 = 32'd5;
    cycles(1);
    div_load8  = 1'b0;
    cycles(12);
    check8("div5 two ticks", 3, 1'b1);
    cycles(2);
    run8      = 1'b0;
    step_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      step_seen |= step8;
    end
    check_output("paused step seen", 32'(step_seen), 32'd0);
    check8("paused", 3, 1'b0);
    run8 = 1'b1;
    cycles(3);
    check8("resume wait", 3, 1'b0);
    cycles(1);
    check8("resume tick", 4, 1'b1);

    cycles(2);
    div_load8 = 1'b1;
    cycles(1);
    div_load8 = 1'b0;
    cycles(5);
    check8("reload mid count wait", 4, 1'b0);
    cycles(1);
    check8("reload mid count tick", 5, 1'b1);

    // div_load on the would-be tick edge suppresses the step.
    cycles(5);
    div_load8  = 1'b1;
    div_value8 = 32'd1;
    cycles(1);
    div_load8  = 1'b0;
    check8("load on tick", 5, 1'b0);
    cycles(1);
    check8("load on tick count", 5, 1'b0);
    cycles(1);
    check8("div1 tick", 6, 1'b1);

    // Mode change on the would-be tick edge.
    cycles(1);
    mode8 = 2'd1;
    cycles(1);
    check8("mode change on tick", 0, 1'b0);
    cycles(1);
    check_output("shift down idle step", 32'(step8), 32'd0);
    cycles(1);
    check8("shift down wrap", 7, 1'b1);
    cycles(2);
    check8("shift down", 6, 1'b1);
    run8 = 1'b0;

    // N=4 bounce; mode change also latches div_value.
    mode4      = 2'd2;
    div_load4  = 1'b1;
    div_value4 = 32'd0;
    cycles(1);
    div_load4  = 1'b0;
    run4       = 1'b1;
    check_output("bounce start pos",  32'(pos4),  32'd0);
    check_output("bounce start leds", 32'(leds4), 32'h1);
    check_output("bounce start step", 32'(step4), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cycles(1);
      check_output("bounce pos",  32'(pos4),  32'(bounce_pos[i]));
      check_output("bounce leds", 32'(leds4), 32'd1 << bounce_pos[i]);
      check_output("bounce step", 32'(step4), 32'd1);
    end

    mode4 = 2'd3;
    cycles(1);
    check_output("fill start pos",  32'(pos4),  32'd0);
    check_output("fill start leds", 32'(leds4), 32'h0);
    check_output("fill start step", 32'(step4), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check_output("fill pos",  32'(pos4),  32'(fill_pos[i]));
      check_output("fill leds", 32'(leds4), 32'(fill_leds[i]));
    end
    cycles(2);
    check_output("fill running pos", 32'(pos4), 32'd2);

    // Asynchronous reset away from the clock edge.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check8("async reset8", 0, 1'b0);
    check_output("async reset4 pos",  32'(pos4),  32'd0);
    check_output("async reset4 leds", 32'(leds4), 32'h1);
    check_output("async reset4 step", 32'(step4), 32'd0);
    mode8 = 2'd0;
    mode4 = 2'd0;
    run4  = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
    check8("after reset", 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
